// File: rtl/led_sched_pkg.sv
// Shared types and constants for the LED pattern scheduler.
//   state_e      : sequencer states (idle, one-cycle init, run, pause)
//   cmd_e        : single button command after priority resolution
//   MODE_*       : pattern selectors carried on the mode output
//   INIT_*       : LED patterns loaded when a pattern (re)starts
package led_sched_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StInit,
    StRun,
    StPause
  } state_e;

  typedef enum logic [1:0] {
    CmdNone,
    CmdStart,
    CmdMode,
    CmdSpeed
  } cmd_e;

  localparam logic [1:0] MODE_ROL   = 2'd0;
  localparam logic [1:0] MODE_ROR   = 2'd1;
  localparam logic [1:0] MODE_PING  = 2'd2;
  localparam logic [1:0] MODE_BLINK = 2'd3;

  localparam logic [7:0] INIT_SINGLE = 8'h01;
  localparam logic [7:0] INIT_BLINK  = 8'hFF;

  // Start beats mode beats speed; losers in the same cycle are dropped.
  function automatic cmd_e resolve_cmd(input logic start, input logic mode, input logic speed);
    if (start) return CmdStart;
    if (mode)  return CmdMode;
    if (speed) return CmdSpeed;
    return CmdNone;
  endfunction

endpackage

// File: rtl/button_debouncer.sv
// Debouncer for one raw push-button.
//   clk       : system clock
//   rst       : asynchronous active-high reset
//   btn_raw   : raw, asynchronous button level
//   btn_level : accepted (debounced) level
//   btn_pulse : one-cycle pulse on each accepted rising edge
// The raw input is synchronised by two flops; the synchronised level must then
// differ from the accepted level for DEBOUNCE consecutive cycles to be taken.
module button_debouncer #(
  parameter int unsigned DEBOUNCE = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_pulse
);

  localparam int unsigned CntW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

  logic            sync1_q, sync2_q;
  logic            level_q, pulse_q;
  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      pulse_q <= 1'b0;
      if (sync2_q == level_q) begin
        // Any return to the accepted level restarts the stability window.
        cnt_q <= '0;
      end else if (cnt_q == CntW'(DEBOUNCE - 1)) begin
        level_q <= sync2_q;
        pulse_q <= sync2_q;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign btn_level = level_q;
  assign btn_pulse = pulse_q;

endmodule

// File: rtl/led_pattern_scheduler.sv
// 8-LED pattern sequencer driven by three debounced buttons.
//   clk       : system clock
//   rst       : asynchronous active-high reset
//   btn_start : raw start/pause button
//   btn_mode  : raw pattern-select button
//   btn_speed : raw speed-select button
//   led       : registered LED drive
//   mode      : registered current pattern
//   speed     : registered current speed (step period = BASE_DELAY >> speed)
//   running   : high only while sequencing (RUN state)
module led_pattern_scheduler #(
  parameter int unsigned BASE_DELAY = 100000000,
  parameter int unsigned DEBOUNCE   = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_start,
  input  logic       btn_mode,
  input  logic       btn_speed,
  output logic [7:0] led,
  output logic [1:0] mode,
  output logic [1:0] speed,
  output logic       running
);

  import led_sched_pkg::*;

  logic [2:0]  btn_level_unused;
  logic        start_pulse, mode_pulse, speed_pulse;
  cmd_e        cmd;

  state_e      state_q;
  logic [7:0]  led_q;
  logic [1:0]  mode_q, speed_q;
  logic [31:0] tick_q;
  logic        dir_left_q;

  logic [31:0] period;
  logic [7:0]  step_led;
  logic        step_dir_left;

  button_debouncer #(.DEBOUNCE(DEBOUNCE)) u_db_start (
    .clk       (clk),
    .rst       (rst),
    .btn_raw   (btn_start),
    .btn_level (btn_level_unused[0]),
    .btn_pulse (start_pulse)
  );

  button_debouncer #(.DEBOUNCE(DEBOUNCE)) u_db_mode (
    .clk       (clk),
    .rst       (rst),
    .btn_raw   (btn_mode),
    .btn_level (btn_level_unused[1]),
    .btn_pulse (mode_pulse)
  );

  button_debouncer #(.DEBOUNCE(DEBOUNCE)) u_db_speed (
    .clk       (clk),
    .rst       (rst),
    .btn_raw   (btn_speed),
    .btn_level (btn_level_unused[2]),
    .btn_pulse (speed_pulse)
  );

  assign cmd    = resolve_cmd(start_pulse, mode_pulse, speed_pulse);
  assign period = BASE_DELAY >> speed_q;

  // Next LED value and ping-pong direction for one pattern step.
  always_comb begin
    step_led      = led_q;
    step_dir_left = dir_left_q;
    unique case (mode_q)
      MODE_ROL: step_led = {led_q[6:0], led_q[7]};
      MODE_ROR: step_led = {led_q[0], led_q[7:1]};
      MODE_PING: begin
        if (dir_left_q) begin
          step_led = {led_q[6:0], 1'b0};
          if (step_led == 8'h80) step_dir_left = 1'b0;
        end else begin
          step_led = {1'b0, led_q[7:1]};
          if (step_led == 8'h01) step_dir_left = 1'b1;
        end
      end
      MODE_BLINK: step_led = ~led_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      led_q      <= 8'h00;
      mode_q     <= MODE_ROL;
      speed_q    <= 2'd0;
      tick_q     <= '0;
      dir_left_q <= 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          led_q <= 8'h00;
          case (cmd)
            CmdStart: state_q <= StInit;
            CmdMode:  mode_q  <= mode_q + 2'd1;
            CmdSpeed: speed_q <= speed_q + 2'd1;
            default:  ;
          endcase
        end
        StInit: begin
          // Pulses arriving here are deliberately ignored.
          led_q      <= (mode_q == MODE_BLINK) ? INIT_BLINK : INIT_SINGLE;
          dir_left_q <= 1'b1;
          tick_q     <= '0;
          state_q    <= StRun;
        end
        StRun: begin
          case (cmd)
            CmdStart: state_q <= StPause;
            CmdMode: begin
              mode_q  <= mode_q + 2'd1;
              state_q <= StInit;
            end
            CmdSpeed: begin
              speed_q <= speed_q + 2'd1;
              tick_q  <= '0;
            end
            default: begin
              if (tick_q == period - 32'd1) begin
                tick_q     <= '0;
                led_q      <= step_led;
                dir_left_q <= step_dir_left;
              end else begin
                tick_q <= tick_q + 32'd1;
              end
            end
          endcase
        end
        StPause: begin
          // led and tick are held so resuming loses no partial period.
          case (cmd)
            CmdStart: state_q <= StRun;
            CmdMode: begin
              mode_q  <= mode_q + 2'd1;
              state_q <= StInit;
            end
            CmdSpeed: begin
              speed_q <= speed_q + 2'd1;
              tick_q  <= '0;
            end
            default: ;
          endcase
        end
      endcase
    end
  end

  assign led     = led_q;
  assign mode    = mode_q;
  assign speed   = speed_q;
  assign running = (state_q == StRun);

endmodule
